fft_bar_feeder: RTL and testbench
=================================

FFT_BAR_FEEDER -- requirements
Module: fft_bar_feeder

Interface
REQ-001 Parameter BINS_PER_BAR, default 4: FFT bins summed into each of the 4 bars.
REQ-002 Parameter SHIFT, default 6: right-shift applied to each bar sum before clipping.
REQ-003 Parameter DECAY, default 8: maximum per-frame decrease of a displayed bar height.
REQ-004 Parameter MAXH, default 480: bar height clip ceiling.
REQ-005 The block SHALL have reset rst, synchronous, active-high, and clock vgaclk.
REQ-006 vgaclk  input  1  pixel clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 bin_valid  input  1  FFT magnitude bin is present.
REQ-009 bin_mag  input  16  unsigned bin magnitude.
REQ-010 bin_last  input  1  final bin of the current FFT frame, qualified by bin_valid.
REQ-011 bin_ready  output  1  block accepts a bin this cycle.
REQ-012 done  input  1  vertical-blanking flag from the VGA renderer; high throughout vblank.
REQ-013 data[3:0]  output  10 each  bar heights driven to the renderer.
REQ-014 update  output  1  one-cycle pulse on the cycle data changes.
REQ-015 missed  output  1  one-cycle pulse when a vblank start passes with no complete bin set.

Function
REQ-016 A bin SHALL be accepted only on cycles where bin_valid and bin_ready are both 1.
REQ-017 The state machine SHALL have two states: ACCUM, in which bin_ready=1, and HOLD, in which bin_ready=0.
REQ-018 In ACCUM, accepted bin k (0-based) SHALL add bin_mag to acc[k/BINS_PER_BAR].
REQ-019 Each acc SHALL be 20 bits wide and SHALL not overflow for BINS_PER_BAR<=16.
REQ-020 The state SHALL go ACCUM->HOLD on acceptance of bin 4*BINS_PER_BAR-1, or earlier on an accepted bin with bin_last=1.
REQ-021 After an early bin_last, bars receiving no bins SHALL keep sum 0.
REQ-022 done SHALL be registered as done_q; vblank start is rise = done & ~done_q.
REQ-023 On rise in HOLD, the block SHALL compute target[b] = min(acc[b]>>SHIFT, MAXH) and then write data[b] as follows:
- if target >= data[b], data[b] = target;
- otherwise data[b] = max(data[b]-DECAY, target).
REQ-024 On the same edge as REQ-023, the block SHALL clear all acc, clear the bin index, enter ACCUM, and pulse update.
REQ-025 data SHALL change only on such commit edges, so the renderer never sees a change outside vblank.
REQ-026 On rise in ACCUM, data SHALL be unchanged, missed SHALL pulse, and the partial accumulation SHALL continue.
REQ-027 If the final bin is accepted on the same cycle as rise, the block SHALL enter HOLD without committing and SHALL commit at the next rise (missed pulses).
REQ-028 done held high SHALL produce exactly one rise.
REQ-029 Commit latency: data and update SHALL be valid on the cycle after the edge on which rise=1 is sampled.
REQ-030 bin_mag accepted in HOLD is impossible because bin_ready=0; bin_valid in HOLD SHALL be ignored.

Reset
REQ-031 On rst=1, the block SHALL set data[0..3]=0, acc=0, bin index=0, state=ACCUM, done_q=1, update=0 and missed=0.
REQ-032 bin_ready SHALL read 0 during the rst cycle and 1 from the first cycle after rst deasserts.
REQ-033 Setting done_q=1 on reset SHALL suppress a spurious rise if done is already high after reset.
REQ-034 rst mid-accumulation or in HOLD SHALL discard all partial sums.

Verification
REQ-035 16 bins of 0x0400, then done rise -> data = {64,64,64,64}, one update pulse, bin_ready=1 next cycle.
REQ-036 16 bins of 0xFFFF (sum 262140>>6=4095) -> all data clip to 480.
REQ-037 From data=480, commit all-zero bins -> data=472, then 464 at the next commit; 0 after 60 commits.
REQ-038 6 bins of 0x0400 with bin_last on the 6th, from zero state -> data = {64,32,0,0}.
REQ-039 done rise while 10 of 16 bins are accepted -> missed pulses, data unchanged; the remaining 6 bins plus the next rise commit the full sums.
REQ-040 rst asserted after 8 bins, then 16 bins of 0x0200 and a rise -> data = {32,32,32,32} with no residue.

Source files
------------

// File: rtl/fft_bar_feeder.sv
// Sums FFT magnitude bins into four bar heights and commits them to the renderer
// only at the start of vertical blanking, with a capped per-frame fall rate.
module fft_bar_feeder #(
    parameter int BINS_PER_BAR = 4,
    parameter int SHIFT        = 6,
    parameter int DECAY        = 8,
    parameter int MAXH         = 480
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic        bin_valid,
    input  logic [15:0] bin_mag,
    input  logic        bin_last,
    output logic        bin_ready,
    input  logic        done,
    output logic [9:0]  data [4],
    output logic        update,
    output logic        missed,
    output logic [0:0]  state_dbg
);

    localparam int NBINS = 4 * BINS_PER_BAR;
    localparam int IW    = $clog2(NBINS);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Handshake: a bin transfers on a rising vgaclk edge where bin_valid and
    // bin_ready are both high; bin_ready depends only on state and rst.
    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [19:0]   acc_q [4];
    logic [19:0]   acc_d [4];
    logic [9:0]    data_q [4];
    logic [9:0]    data_d [4];
    logic          done_q, done_d;
    logic          update_q, update_d;
    logic          missed_q, missed_d;

    logic          rise;
    logic          accept;
    logic [1:0]    bar;
    logic [19:0]   shifted [4];
    logic [9:0]    target [4];
    logic [9:0]    new_h [4];

    assign bin_ready = ~rst & (state_q == ST_ACCUM);
    assign accept    = bin_valid & bin_ready;
    assign rise      = done & ~done_q;

    // Next displayed height per bar: jump up immediately, fall by at most DECAY.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            shifted[b] = acc_q[b] >> SHIFT;
            target[b]  = (shifted[b] > 20'(MAXH)) ? 10'(MAXH) : shifted[b][9:0];
            if (target[b] >= data_q[b]) begin
                new_h[b] = target[b];
            end else if (12'(data_q[b]) > 12'(target[b]) + 12'(DECAY)) begin
                new_h[b] = data_q[b] - 10'(DECAY);
            end else begin
                new_h[b] = target[b];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        data_d   = data_q;
        done_d   = done;
        update_d = 1'b0;
        missed_d = 1'b0;
        bar      = '0;
        if (state_q == ST_ACCUM) begin
            if (accept) begin
                bar        = 2'(idx_q / IW'(BINS_PER_BAR));
                acc_d[bar] = acc_q[bar] + 20'(bin_mag);
                idx_d      = idx_q + IW'(1);
                if (idx_q == IW'(NBINS - 1) || bin_last) begin
                    state_d = ST_HOLD;
                end
            end
            // A set that completes on the rise edge itself still waits a frame.
            if (rise) begin
                missed_d = 1'b1;
            end
        end else if (rise) begin
            for (int b = 0; b < 4; b++) begin
                data_d[b] = new_h[b];
                acc_d[b]  = '0;
            end
            idx_d    = '0;
            state_d  = ST_ACCUM;
            update_d = 1'b1;
        end
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q  <= ST_ACCUM;
            idx_q    <= '0;
            done_q   <= 1'b1;
            update_q <= 1'b0;
            missed_q <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                acc_q[b]  <= '0;
                data_q[b] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            update_q <= update_d;
            missed_q <= missed_d;
            for (int b = 0; b < 4; b++) begin
                acc_q[b]  <= acc_d[b];
                data_q[b] <= data_d[b];
            end
        end
    end

    assign data      = data_q;
    assign update    = update_q;
    assign missed    = missed_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_bar_feeder.sv
// Bench for fft_bar_feeder: a frame-level reference model predicts every
// update/missed event; a negedge monitor pops and compares them.
module tb_fft_bar_feeder;

    localparam int BPB   = 4;
    localparam int NB    = 4 * BPB;
    localparam int SHIFT = 6;
    localparam int DECAY = 8;
    localparam int MAXH  = 480;

    logic        vgaclk;
    logic        rst;
    logic        bin_valid;
    logic [15:0] bin_mag;
    logic        bin_last;
    logic        bin_ready;
    logic        done;
    logic [9:0]  data [4];
    logic        update;
    logic        missed;
    logic [0:0]  state_dbg;

    fft_bar_feeder #(
        .BINS_PER_BAR(BPB), .SHIFT(SHIFT), .DECAY(DECAY), .MAXH(MAXH)
    ) dut (
        .vgaclk(vgaclk), .rst(rst), .bin_valid(bin_valid), .bin_mag(bin_mag),
        .bin_last(bin_last), .bin_ready(bin_ready), .done(done), .data(data),
        .update(update), .missed(missed), .state_dbg(state_dbg)
    );

    // clock / reset
    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    int total = 0;
    int bad   = 0;

    // bit 40: 1 = missed event, 0 = update event; bits 39:0 = expected heights
    logic [40:0] exp_q[$];

    // reference model: displayed heights and the bins of the frame in progress
    int m_data [4];
    int frame[$];
    bit m_complete;
    bit m_prev_done;

    function automatic logic [39:0] model_packed();
        return {10'(m_data[3]), 10'(m_data[2]), 10'(m_data[1]), 10'(m_data[0])};
    endfunction

    function automatic logic [39:0] dut_packed();
        return {data[3], data[2], data[1], data[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_commit();
        for (int b = 0; b < 4; b++) begin
            int sum;
            int t;
            sum = 0;
            foreach (frame[k]) if (k / BPB == b) sum += frame[k];
            t = sum >> SHIFT;
            if (t > MAXH) t = MAXH;
            if (t >= m_data[b]) m_data[b] = t;
            else if (m_data[b] - DECAY > t) m_data[b] = m_data[b] - DECAY;
            else m_data[b] = t;
        end
        frame.delete();
        m_complete = 1'b0;
    endfunction

    // scoreboard monitor
    always @(negedge vgaclk) begin
        if (update === 1'b1 || missed === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got update=%0b missed=%0b want none at %0t",
                         update, missed, $time);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                check("event_kind", {62'd0, update, missed}, e[40] ? 64'd1 : 64'd2);
                check("event_data", 64'(dut_packed()), 64'(e[39:0]));
            end
        end
    end

    // driver: one clock of stimulus, model step, then a check that nothing was lost
    task automatic tick(input bit v, input logic [15:0] m, input bit l, input bit d);
        bit was;
        bit r;
        bin_valid = v;
        bin_mag   = m;
        bin_last  = l;
        done      = d;
        #1;
        check("bin_ready", 64'(bin_ready), 64'(!m_complete));
        check("state_dbg", 64'(state_dbg), 64'(m_complete));
        was = m_complete;
        r = d && !m_prev_done;
        m_prev_done = d;
        if (v && !was) begin
            frame.push_back(int'(m));
            if (frame.size() == NB || l) m_complete = 1'b1;
        end
        if (r) begin
            if (was) begin
                model_commit();
                exp_q.push_back({1'b0, model_packed()});
            end else begin
                exp_q.push_back({1'b1, model_packed()});
            end
        end
        @(posedge vgaclk);
        @(negedge vgaclk);
        #1;
        check("events_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input bit d);
        rst       = 1'b1;
        bin_valid = 1'b0;
        bin_mag   = '0;
        bin_last  = 1'b0;
        done      = d;
        #1;
        check("ready_in_rst", 64'(bin_ready), 64'd0);
        @(posedge vgaclk);
        @(negedge vgaclk);
        #1;
        rst = 1'b0;
        for (int b = 0; b < 4; b++) m_data[b] = 0;
        frame.delete();
        m_complete  = 1'b0;
        m_prev_done = 1'b1;
        exp_q.delete();
        check("rst_data", 64'(dut_packed()), 64'd0);
        check("rst_pulses", {62'd0, update, missed}, 64'd0);
    endtask

    task automatic send_frame(input logic [15:0] m, input int n, input bit last);
        for (int i = 0; i < n; i++) tick(1'b1, m, last && (i == n - 1), 1'b0);
    endtask

    task automatic vblank();
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic check_data(input string name, input int d0, input int d1, input int d2, input int d3);
        check(name, 64'(dut_packed()), 64'({10'(d3), 10'(d2), 10'(d1), 10'(d0)}));
    endtask

    initial begin
        rst = 1'b1;
        bin_valid = 1'b0;
        bin_mag = '0;
        bin_last = 1'b0;
        done = 1'b1;

        // done already high out of reset must not count as a vblank start
        do_reset(1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        check_data("no_spurious_rise", 0, 0, 0, 0);

        send_frame(16'h0400, NB, 1'b0);
        tick(1'b1, 16'hFFFF, 1'b0, 1'b0);   // ignored while holding
        vblank();
        check_data("flat_0400", 64, 64, 64, 64);

        send_frame(16'hFFFF, NB, 1'b0);
        vblank();
        check_data("clip_max", 480, 480, 480, 480);

        for (int i = 0; i < 60; i++) begin
            send_frame(16'h0000, NB, 1'b0);
            vblank();
            if (i == 0) check_data("decay_1", 472, 472, 472, 472);
            if (i == 1) check_data("decay_2", 464, 464, 464, 464);
        end
        check_data("decay_60", 0, 0, 0, 0);

        send_frame(16'h0400, 6, 1'b1);
        vblank();
        check_data("early_last", 64, 32, 0, 0);

        send_frame(16'h0400, 10, 1'b0);
        vblank();
        check_data("missed_keeps", 64, 32, 0, 0);
        send_frame(16'h0400, 6, 1'b0);
        vblank();
        check_data("missed_then_full", 64, 64, 64, 64);

        // last bin lands on the rise edge: missed now, commit at next rise
        send_frame(16'h0800, NB - 1, 1'b0);
        tick(1'b1, 16'h0800, 1'b0, 1'b1);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        check_data("final_on_rise", 64, 64, 64, 64);
        vblank();
        check_data("final_on_rise_commit", 128, 128, 128, 128);

        send_frame(16'hFFFF, 8, 1'b0);
        do_reset(1'b0);
        send_frame(16'h0200, NB, 1'b0);
        vblank();
        check_data("rst_discards", 32, 32, 32, 32);

        send_frame(16'h1000, NB, 1'b0);
        do_reset(1'b0);
        send_frame(16'h0200, NB, 1'b0);
        vblank();
        check_data("rst_in_hold", 32, 32, 32, 32);

        // randomized traffic with a free-running vblank pattern
        begin
            bit d;
            int cnt;
            d = 1'b0;
            cnt = $urandom_range(5, 40);
            for (int i = 0; i < 3000; i++) begin
                logic [15:0] m;
                case ($urandom_range(0, 3))
                    0: m = 16'($urandom_range(0, 1023));
                    1: m = 16'($urandom);
                    2: m = 16'hFFFF;
                    default: m = 16'h0000;
                endcase
                if (cnt == 0) begin
                    d = !d;
                    cnt = d ? $urandom_range(1, 5) : $urandom_range(5, 40);
                end else begin
                    cnt--;
                end
                tick($urandom_range(0, 3) != 0, m, $urandom_range(0, 15) == 0, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
